// File: rtl/ins_block_refill_pkg.sv
// Shared constants for the instruction-cache refill engine: block geometry
// and FSM state encodings.
package ins_block_refill_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int OFFSET_W        = 4;
  localparam int CNT_W           = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/ins_block_refill.sv
// I-cache refill engine: fetches the four words of a missed block one at a
// time and issues a single registered write strobe to the cache data array.
module ins_block_refill
  import ins_block_refill_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               miss_req,
  input  logic [ADDR_W-1:0]                  miss_addr,
  output logic                               busy,
  output logic                               mem_read,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic                               mem_ack,
  input  logic [WORD_W-1:0]                  mem_readdata,
  output logic                               fill_valid,
  output logic [BLOCK_W-1:0]                 fill_block,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] fill_tag,
  output logic [INDEX_W-1:0]                 fill_index
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [LINE_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   words_q [WORDS_PER_BLOCK];
  logic [WORD_W-1:0]   words_d [WORDS_PER_BLOCK];
  logic                busy_q, busy_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                fill_valid_q, fill_valid_d;
  logic [BLOCK_W-1:0]  fill_block_q, fill_block_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [INDEX_W-1:0]  fill_index_q, fill_index_d;

  // Next-state logic. busy stays high through the strobe cycle so a new miss
  // cannot be accepted while fill_valid is still being presented.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    base_d       = base_q;
    words_d      = words_q;
    busy_d       = busy_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    fill_valid_d = 1'b0;
    fill_block_d = fill_block_q;
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req && !busy_q) begin
          base_d     = miss_addr[ADDR_W-1:OFFSET_W];
          word_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_FETCH;
          busy_d     = 1'b1;
          mem_read_d = 1'b1;
          mem_addr_d = {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        end else begin
          busy_d     = 1'b0;
          mem_read_d = 1'b0;
        end
      end
      ST_FETCH: begin
        busy_d     = 1'b1;
        mem_read_d = 1'b1;
        if (mem_ack) begin
          words_d[word_cnt_q] = mem_readdata;
          if (word_cnt_q == 2'd3) begin
            word_cnt_d = {CNT_W{1'b0}};
            mem_read_d = 1'b0;
            state_d    = ST_WRITE;
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
            mem_addr_d = {base_q, word_cnt_q + 2'd1, 2'b00};
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      ST_WRITE: begin
        busy_d       = 1'b1;
        mem_read_d   = 1'b0;
        fill_valid_d = 1'b1;
        fill_block_d = {words_q[3], words_q[2], words_q[1], words_q[0]};
        fill_tag_d   = base_q[LINE_W-1:INDEX_W];
        fill_index_d = base_q[INDEX_W-1:0];
        state_d      = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        mem_read_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partially collected block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= {CNT_W{1'b0}};
      base_q       <= {LINE_W{1'b0}};
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        words_q[i] <= {WORD_W{1'b0}};
      end
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      fill_valid_q <= 1'b0;
      fill_block_q <= {BLOCK_W{1'b0}};
      fill_tag_q   <= {TAG_W{1'b0}};
      fill_index_q <= {INDEX_W{1'b0}};
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      base_q       <= base_d;
      words_q      <= words_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_block_q <= fill_block_d;
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
    end
  end

  assign busy       = busy_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign fill_valid = fill_valid_q;
  assign fill_block = fill_block_q;
  assign fill_tag   = fill_tag_q;
  assign fill_index = fill_index_q;

endmodule

// File: tb/tb_ins_block_refill.sv
// Self-checking bench for ins_block_refill: directed vector table, reset and
// spurious-ack sequences, then randomized misses against a behavioural model.
module tb_ins_block_refill;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          miss_req;
  logic [9:0]    miss_addr;
  logic          busy;
  logic          mem_read;
  logic [9:0]    mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_readdata;
  logic          fill_valid;
  logic [127:0]  fill_block;
  logic [2:0]    fill_tag;
  logic [2:0]    fill_index;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] last_block = 128'd0;

  typedef struct packed {
    logic [9:0]   addr;
    logic [127:0] data;      // word k returned for offset k, at [32k+31:32k]
    logic [15:0]  waits;     // wait cycles before the ack of word k, at [4k+3:4k]
    logic         pulse;     // hammer miss_req with other addresses during FETCH
    logic [2:0]   exp_tag;
    logic [2:0]   exp_idx;
    logic [127:0] exp_block;
  } vec_t;

  vec_t vecs [4];

  ins_block_refill dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .busy         (busy),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_readdata (mem_readdata),
    .fill_valid   (fill_valid),
    .fill_block   (fill_block),
    .fill_tag     (fill_tag),
    .fill_index   (fill_index)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"},       128'(busy),       128'd0);
    chk({nm, ".mem_read"},   128'(mem_read),   128'd0);
    chk({nm, ".mem_addr"},   128'(mem_addr),   128'd0);
    chk({nm, ".fill_valid"}, 128'(fill_valid), 128'd0);
    chk({nm, ".fill_block"}, fill_block,       128'd0);
    chk({nm, ".fill_tag"},   128'(fill_tag),   128'd0);
    chk({nm, ".fill_index"}, 128'(fill_index), 128'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle.busy",       128'(busy),       128'd0);
      chk("idle.mem_read",   128'(mem_read),   128'd0);
      chk("idle.fill_valid", 128'(fill_valid), 128'd0);
      chk("idle.block_held", fill_block,       last_block);
    end
  endtask

  // One complete miss, checked cycle by cycle; entered and left at a negedge.
  task automatic run_miss(input logic [9:0] addr, input logic [127:0] data,
                          input logic [15:0] waits, input logic pulse,
                          input logic [2:0] exp_tag, input logic [2:0] exp_idx,
                          input logic [127:0] exp_block);
    logic [9:0] base;
    int wt;
    base = addr & 10'h3F0;
    @(negedge clock);
    miss_req  = 1'b1;
    miss_addr = addr;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      wt = int'(waits[4*k +: 4]);
      for (int w = 0; w <= wt; w++) begin
        chk("fetch.busy",     128'(busy),     128'd1);
        chk("fetch.mem_read", 128'(mem_read), 128'd1);
        chk("fetch.mem_addr", 128'(mem_addr), 128'(10'(base + 10'(4 * k))));
        chk("fetch.no_fill",  128'(fill_valid), 128'd0);
        mem_ack      = (w == wt);
        mem_readdata = (w == wt) ? data[32*k +: 32] : $urandom;
        if (pulse) begin
          miss_req  = 1'b1;
          miss_addr = 10'($urandom);
        end else begin
          miss_req  = 1'b0;
        end
        @(negedge clock);
      end
    end
    miss_req     = 1'b0;
    mem_ack      = 1'b0;
    mem_readdata = 32'hFFFF_FFFF;
    chk("write.fill_early", 128'(fill_valid), 128'd0);
    chk("write.mem_read",   128'(mem_read),   128'd0);
    chk("write.busy",       128'(busy),       128'd1);
    @(negedge clock);
    chk("fill.valid",  128'(fill_valid), 128'd1);
    chk("fill.block",  fill_block,       exp_block);
    chk("fill.tag",    128'(fill_tag),   128'(exp_tag));
    chk("fill.index",  128'(fill_index), 128'(exp_idx));
    chk("fill.busy",   128'(busy),       128'd1);
    last_block = exp_block;
    @(negedge clock);
    chk("after.valid",  128'(fill_valid), 128'd0);
    chk("after.busy",   128'(busy),       128'd0);
    chk("after.block",  fill_block,       exp_block);
  endtask

  initial begin
    logic [31:0]  words [4];
    logic [9:0]   raddr;
    logic [127:0] rdata;
    logic [127:0] rblock;
    logic [15:0]  rwaits;

    vecs[0] = '{addr: 10'h1A6, data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, waits: 16'h0000,
                pulse: 1'b0, exp_tag: 3'd3, exp_idx: 3'd2,
                exp_block: {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};
    vecs[1] = '{addr: 10'h1A6, data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, waits: 16'h0030,
                pulse: 1'b0, exp_tag: 3'd3, exp_idx: 3'd2,
                exp_block: {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};
    vecs[2] = '{addr: 10'h3FF, data: {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hDEAD_BEEF},
                waits: 16'h1021, pulse: 1'b1, exp_tag: 3'd7, exp_idx: 3'd7,
                exp_block: {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hDEAD_BEEF}};
    vecs[3] = '{addr: 10'h00C, data: {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                waits: 16'h2000, pulse: 1'b1, exp_tag: 3'd0, exp_idx: 3'd0,
                exp_block: {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};

    reset_n      = 1'b0;
    miss_req     = 1'b0;
    miss_addr    = 10'd0;
    mem_ack      = 1'b0;
    mem_readdata = 32'd0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle_check(2);

    for (int v = 0; v < 4; v++) begin
      run_miss(vecs[v].addr, vecs[v].data, vecs[v].waits, vecs[v].pulse,
               vecs[v].exp_tag, vecs[v].exp_idx, vecs[v].exp_block);
      idle_check(3);
    end

    // Spurious acks while idle must not start anything or disturb the block.
    mem_ack      = 1'b1;
    mem_readdata = 32'h0000_00FF;
    idle_check(3);
    mem_ack      = 1'b0;

    // Reset after two acks: no strobe, outputs cleared at once, restart at word0.
    @(negedge clock);
    miss_req  = 1'b1;
    miss_addr = 10'h2B4;
    @(negedge clock);
    miss_req     = 1'b0;
    mem_ack      = 1'b1;
    mem_readdata = 32'h0000_0011;
    @(negedge clock);
    mem_readdata = 32'h0000_0022;
    @(negedge clock);
    mem_ack = 1'b0;
    chk("abort.mem_addr", 128'(mem_addr), 128'(10'h2B8));
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clock);
    reset_n = 1'b1;
    last_block = 128'd0;
    idle_check(2);
    run_miss(10'h2B4, {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011},
             16'h0101, 1'b0, 3'd5, 3'd3,
             {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011});

    // Randomized misses against the address/tag/block model.
    for (int t = 0; t < 20; t++) begin
      raddr  = 10'($urandom);
      rdata  = 128'd0;
      rblock = 128'd0;
      rwaits = 16'd0;
      for (int k = 0; k < 4; k++) begin
        words[k] = $urandom;
        rdata[32*k +: 32]  = words[k];
        rwaits[4*k +: 4]   = 4'($urandom_range(0, 2));
        rblock = rblock | (128'(words[k]) << (32 * k));
      end
      run_miss(raddr, rdata, rwaits, 1'($urandom), 3'(raddr / 128), 3'((raddr / 16) % 8), rblock);
      idle_check(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
